// File: rtl/subtractor_pipe.sv
`default_nettype none
// ============================================================================
// subtractor_pipe : N-stage segmented ripple-borrow subtractor, SEG bits/stage
// Revision        : 1.0
// ============================================================================
module subtractor_pipe #(
   parameter int WIDTH = 1024,
   parameter int SEG   = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             borrow_out
);

   localparam int N = WIDTH / SEG;

   logic advance;

   // The whole pipe moves as one; the last stage doubles as the output register.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < N; k++) begin : g_stage
      localparam int RW = (k + 1) * SEG;
      localparam int UW = WIDTH - k * SEG;

      logic          up_valid;
      logic          up_borrow;
      logic [UW-1:0] a_up;
      logic [UW-1:0] b_up;
      logic [SEG:0]  diff;
      logic          valid_d;
      logic          valid_q;
      logic          borrow_d;
      logic          borrow_q;
      logic [RW-1:0] res_d;
      logic [RW-1:0] res_q;

      // a_up/b_up hold only the operand segments this item has not consumed yet.
      if (k == 0) begin : g_src
         assign up_valid  = in_valid;
         assign up_borrow = 1'b0;
         assign a_up      = in1;
         assign b_up      = in2;
         always_comb res_d = diff[SEG-1:0];
      end else begin : g_src
         assign up_valid  = g_stage[k-1].valid_q;
         assign up_borrow = g_stage[k-1].borrow_q;
         assign a_up      = g_stage[k-1].g_skew.a_q;
         assign b_up      = g_stage[k-1].g_skew.b_q;
         always_comb res_d = {diff[SEG-1:0], g_stage[k-1].res_q};
      end

      assign diff = {1'b0, a_up[SEG-1:0]} - {1'b0, b_up[SEG-1:0]}
                  - {{SEG{1'b0}}, up_borrow};

      always_comb begin
         valid_d  = up_valid;
         borrow_d = diff[SEG];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q  <= 1'b0;
            borrow_q <= 1'b0;
            res_q    <= '0;
         end else if (advance) begin
            valid_q  <= valid_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
         end
      end

      if (k < N - 1) begin : g_skew
         localparam int SW = UW - SEG;

         logic [SW-1:0] a_d;
         logic [SW-1:0] a_q;
         logic [SW-1:0] b_d;
         logic [SW-1:0] b_q;

         always_comb begin
            a_d = a_up[UW-1:SEG];
            b_d = b_up[UW-1:SEG];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end

   assign out_valid  = g_stage[N-1].valid_q;
   assign out        = g_stage[N-1].res_q;
   assign borrow_out = g_stage[N-1].borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// tb_subtractor_pipe : directed vectors, corner sequences and random traffic
// Revision           : 1.0
// ============================================================================
module tb_subtractor_pipe;

   localparam int W  = 1024;
   localparam int S  = 256;
   localparam int W1 = W + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   r;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         borrow_out;

   int           checks = 0;
   int           fails  = 0;
   logic [W:0]   exp_q[$];
   logic         hold_prev = 1'b0;
   logic [W:0]   out_prev;

   subtractor_pipe #(.WIDTH(W), .SEG(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in1        (in1),
      .in2        (in2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   // {borrow, difference} straight from unsigned arithmetic
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] d;
      d = a - b;
      return {(a < b), d};
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual hi=%h lo=%h required hi=%h lo=%h",
                  name, act[W:W-63], act[63:0], req[W:W-63], req[63:0]);
      end
   endtask

   // One clock cycle: drive, check the pre-edge state, then apply the edge.
   task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy, output logic popped, output logic [W:0] got);
      logic acc;
      in_valid  = v;
      in1       = a;
      in2       = b;
      out_ready = ordy;
      #1;
      if (hold_prev) begin
         chk("stall_hold", {borrow_out, out}, out_prev);
         chk("stall_valid", W1'(out_valid), W1'(1'b1));
      end
      chk("in_ready_rule", W1'(in_ready), W1'(!out_valid || ordy));
      acc    = v && in_ready;
      popped = out_valid && ordy;
      got    = {borrow_out, out};
      if (popped) begin
         if (exp_q.size() == 0) chk("spurious_output", W1'(out_valid), '0);
         else                   chk("result_order", got, exp_q.pop_front());
      end
      hold_prev = out_valid && !ordy;
      out_prev  = got;
      @(posedge clk);
      if (acc) exp_q.push_back(model(a, b));
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in1       = rnd();
      in2       = rnd();
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", W1'(out_valid), '0);
      chk("rst_in_ready", W1'(in_ready), W1'(1'b1));
      chk("rst_out_zero", {borrow_out, out}, '0);
      rst       = 1'b0;
      in_valid  = 1'b0;
      exp_q.delete();
      hold_prev = 1'b0;
   endtask

   // Single item into an empty pipe: result value and acceptance-to-output latency.
   task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] req);
      logic       p;
      logic [W:0] g;
      int         n;
      cycle(1'b1, a, b, 1'b1, p, g);
      n = 0;
      p = 1'b0;
      while (!p && n < 16) begin
         cycle(1'b0, '0, '0, 1'b1, p, g);
         n++;
      end
      chk({name, "_latency"}, W1'(n), W1'(4));
      chk({name, "_result"}, g, req);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, actual running required finished");
      $fatal(1);
   end

   initial begin
      vec_t         vt[6];
      logic [W-1:0] zero;
      logic [W-1:0] ones;
      logic [W-1:0] p256;
      logic [W-1:0] lo256;
      logic [W-1:0] x;
      logic [W-1:0] a0;
      logic [W-1:0] b0;
      logic [W:0]   g;
      logic         p;
      logic         v;
      logic         ordy;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      zero  = '0;
      ones  = '1;
      p256  = '0;
      p256[S] = 1'b1;
      lo256 = '0;
      lo256[S-1:0] = '1;
      x     = rnd();

      vt[0] = '{W'(5), W'(3), W1'(2)};
      vt[1] = '{zero, W'(1), {1'b1, ones}};
      vt[2] = '{p256, W'(1), {1'b0, lo256}};
      vt[3] = '{x, x, {1'b0, zero}};
      vt[4] = '{ones, zero, {1'b0, ones}};
      vt[5] = '{zero, ones, {1'b1, W'(1)}};

      rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
      do_reset();

      for (int i = 0; i < 6; i++) single($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].r);

      // four back-to-back operands leave on four consecutive cycles
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, rnd(), rnd(), 1'b1, p, g);
         chk("burst_no_early", W1'(p), '0);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, zero, zero, 1'b1, p, g);
         chk("burst_back_to_back", W1'(p), W1'(1'b1));
      end
      cycle(1'b0, zero, zero, 1'b1, p, g);
      chk("burst_end", W1'(p), '0);
      chk("burst_drained", W1'(exp_q.size()), '0);

      // output stalled for three cycles with a result pending
      a0 = rnd();
      b0 = rnd();
      cycle(1'b1, a0, b0, 1'b1, p, g);
      cycle(1'b1, rnd(), rnd(), 1'b1, p, g);
      cycle(1'b0, zero, zero, 1'b1, p, g);
      cycle(1'b0, zero, zero, 1'b1, p, g);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, rnd(), rnd(), 1'b0, p, g);
         chk("stall_first_result", g, model(a0, b0));
         chk("stall_in_ready", W1'(in_ready), '0);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle(1'b0, zero, zero, 1'b1, p, g);
      chk("stall_drained", W1'(exp_q.size()), '0);

      // reset with two items in flight
      cycle(1'b1, rnd(), rnd(), 1'b1, p, g);
      cycle(1'b1, rnd(), rnd(), 1'b1, p, g);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, zero, zero, 1'b1, p, g);
         chk("flush_no_output", W1'(p), '0);
      end
      single("post_reset", W'(5), W'(3), W1'(2));

      // random traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         ra   = rnd();
         rb   = ($urandom_range(0, 7) == 0) ? ra : rnd();
         cycle(v, ra, rb, ordy, p, g);
      end
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, zero, zero, 1'b1, p, g);
      chk("random_drained", W1'(exp_q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/subtractor_pipe.md
SUBTRACTOR_PIPE -- requirements
Module: subtractor_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1024, operand and result width in bits.
REQ-002 The block SHALL have parameter SEG, default 256, segment width; WIDTH SHALL be an integer multiple of SEG; N = WIDTH/SEG (default 4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 The block SHALL have port in1, input, WIDTH bits: minuend, unsigned.
REQ-008 The block SHALL have port in2, input, WIDTH bits: subtrahend, unsigned.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out and borrow_out hold a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-011 The block SHALL have port out, output, WIDTH bits: the registered result (in1 - in2) mod 2^WIDTH.
REQ-012 The block SHALL have port borrow_out, output, 1 bit: registered; 1 iff in1 < in2, unsigned.

Function
REQ-013 Operands SHALL be accepted on a rising edge where in_valid && in_ready; this is the acceptance edge.
REQ-014 advance SHALL be defined as !out_valid || out_ready; in_ready SHALL equal advance combinationally, including during rst.
REQ-015 The pipeline SHALL have N stages, each carrying a valid bit; on !advance every stage register SHALL hold its value, including valid, data and borrow.
REQ-016 Stage k (k = 0..N-1) SHALL compute difference segment k, bits [k*SEG+SEG-1 : k*SEG], as in1_seg - in2_seg - borrow_{k-1}, with borrow_{-1} = 0; it SHALL register that SEG-bit difference and borrow_k.
REQ-017 Upper operand segments not yet consumed SHALL travel with the item via skew registers; lower result segments already produced SHALL travel via deskew registers, so that all N segments of one item appear on out together.
REQ-018 Latency: out_valid SHALL rise on the Nth rising edge with advance = 1, counting the acceptance edge as the 1st; with defaults and no stall, acceptance at edge E gives a result visible after edge E+3.
REQ-019 Throughput SHALL be one item per cycle when out_ready = 1; results SHALL leave in acceptance order, with no loss and no duplication.
REQ-020 A cycle with in_valid = 0 and advance = 1 SHALL insert a bubble (stage-0 valid = 0); bubbles SHALL never raise out_valid.
REQ-021 borrow_out SHALL equal borrow_{N-1} of the same item as out.
REQ-022 While out_valid && !out_ready, out and borrow_out SHALL remain stable.
REQ-023 Simultaneous handshakes SHALL be supported: on an edge with out_valid && out_ready and a valid item in the last stage, out SHALL load the next result with no gap.
REQ-024 The arithmetic SHALL wrap modulo 2^WIDTH; in1 = in2 SHALL give out = 0 and borrow_out = 0.

Reset
REQ-025 On a rising edge with rst = 1, all stage valid bits and out_valid SHALL clear to 0, and out, borrow_out and all data registers SHALL clear to 0.
REQ-026 Reset SHALL take priority over acceptance; operands presented during a reset edge SHALL be discarded.
REQ-027 A reset mid-operation SHALL flush all in-flight items, and none of them SHALL appear at out afterwards.
REQ-028 After rst deasserts, in_ready SHALL be 1 and the first accepted item SHALL obey REQ-018.

Verification
REQ-029 The bench SHALL check in1 = 5, in2 = 3, out_ready = 1 -> out = 2, borrow_out = 0, out_valid exactly 4 edges after acceptance, counting the acceptance edge.
REQ-030 The bench SHALL check in1 = 0, in2 = 1 -> out = all ones (2^1024 - 1), borrow_out = 1, which confirms borrow through all 4 segments.
REQ-031 The bench SHALL check in1 = 2^256, in2 = 1 -> out[255:0] = all ones, out[1023:256] = 0, borrow_out = 0, which confirms the cross-segment borrow.
REQ-032 The bench SHALL check 4 operand pairs on consecutive cycles with out_ready = 1 -> 4 correct results on 4 consecutive cycles, in order.
REQ-033 The bench SHALL check out_ready = 0 for 3 cycles while a result is pending -> out is held, in_ready = 0, no item is lost; on out_ready = 1 the remaining results drain in order.
REQ-034 The bench SHALL check rst pulsed for 1 cycle with 2 items in flight -> out_valid = 0 after the reset edge, neither item is ever output, and in_ready = 1.
